// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// Holds the FIFO handshake FSM encoding and the default FIFO depth.
package uart_pkg;

  typedef enum logic [1:0] {
    TXF_IDLE,
    TXF_PRESENT,
    TXF_RELEASE
  } txf_state_t;

  localparam int UART_TXF_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage for uart_tx_fifo.
// Clocked write port plus a combinational read port.
module uart_tx_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx over a 4-phase valid/ack handshake.
// Define UART_TX_FIFO_OVF_EN to add the sticky ovf flag and ovf_clr.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TXF_DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  wr_data,
  input  logic        wr_en,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level,
  output logic [7:0]  data,
  output logic        data_valid,
`ifdef UART_TX_FIFO_OVF_EN
  output logic        ovf,
  input  logic        ovf_clr,
`endif
  input  logic        tx_ack
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  txf_state_t    state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    rd_data;
  logic          push;
  logic          pop;

  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign level      = count_q;
  assign data       = data_q;
  assign data_valid = valid_q;

  // full is the pre-pop value, so a write while full is dropped
  // even when the same edge pops.
  assign push = wr_en && !full;
  assign pop  = (state_q == TXF_PRESENT) && tx_ack;

  uart_tx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case (1'b1)
      (push && !pop): count_d = count_q + ONE_C;
      (pop && !push): count_d = count_q - ONE_C;
      default:        count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      TXF_IDLE: begin
        // A stale ack left over from uart_tx blocks a new request.
        if (!empty && !tx_ack) begin
          data_d  = rd_data;
          valid_d = 1'b1;
          state_d = TXF_PRESENT;
        end
      end
      TXF_PRESENT: begin
        if (tx_ack) begin
          valid_d = 1'b0;
          state_d = TXF_RELEASE;
        end
      end
      TXF_RELEASE: begin
        valid_d = 1'b0;
        if (!tx_ack) begin
          state_d = TXF_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = TXF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TXF_IDLE;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    unique case (1'b1)
      (wr_en && full): ovf_d = 1'b1;
      ovf_clr:         ovf_d = 1'b0;
      default:         ovf_d = ovf_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table plus handshake sequences.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic [7:0] data;
  logic       data_valid;
  logic       tx_ack;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf;
  logic       ovf_clr;
`endif

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .data       (data),
    .data_valid (data_valid),
`ifdef UART_TX_FIFO_OVF_EN
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
`endif
    .tx_ack     (tx_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       ack;
    logic       v;
    logic [7:0] d;
    logic [4:0] lvl;
    logic       e;
    logic       f;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic chk_vals);
    wr_en = 1'b0;
    wr_data = 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    rst_n = 1'b0;
    #3;
    if (chk_vals) begin
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_data", 32'(data), 32'h00);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Full 4-phase handshake for one byte with a bounded wait.
  task automatic recv(input logic [7:0] exp, input string nm);
    int n;
    n = 0;
    while (!data_valid && n < 60) begin
      step();
      n++;
    end
    if (!data_valid) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_data"}, 32'(data), 32'(exp));
      tx_ack = 1'b1;
      step();
      chk({nm, "_drop"}, 32'(data_valid), 32'd0);
      tx_ack = 1'b0;
      step();
      chk({nm, "_rel"}, 32'(data_valid), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] b;
    int sent;
    int got;
    int cyc;

    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 5'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h11, 5'd3, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 5'd3, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 5'd3, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 5'd3, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 5'd2, 1'b0, 1'b0};

    tx_ack = 1'b0;
    do_reset(1'b1);

    // Single byte, then simultaneous write and pop at level 3.
    for (int i = 0; i < 15; i++) begin
      wr_en = vecs[i].wr;
      wr_data = vecs[i].wd;
      tx_ack = vecs[i].ack;
      step();
      chk($sformatf("v%0d_valid", i), 32'(data_valid), 32'(vecs[i].v));
      chk($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].d));
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].f));
    end
    wr_en = 1'b0;
    tx_ack = 1'b0;
    step();
    recv(8'h33, "sim_b33");
    recv(8'h44, "sim_b44");
    chk("sim_empty", 32'(empty), 32'd1);

    // Burst fill to full, overflow, then drain in order.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      step();
    end
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_level", 32'(level), 32'd16);
    wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_full", 32'(full), 32'd1);
`ifdef UART_TX_FIFO_OVF_EN
    chk("ovf_set", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    step();
    chk("ovf_clr", 32'(ovf), 32'd0);
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    step();
    chk("ovf_sticky", 32'(ovf), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      recv(8'(i), $sformatf("burst_b%0d", i));
    end
    chk("burst_empty", 32'(empty), 32'd1);
    repeat (3) step();
    chk("burst_idle", 32'(data_valid), 32'd0);

    // Pointer wrap with random gaps on both sides.
    do_reset(1'b0);
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < 40 && cyc < 5000) begin
      step();
      cyc++;
      if (!tx_ack && data_valid) begin
        if (q.size() == 0) begin
          chk($sformatf("wrap_%0d_extra", got), 32'(data), 32'hFFFF);
        end else begin
          b = q.pop_front();
          chk($sformatf("wrap_%0d", got), 32'(data), 32'(b));
        end
        got++;
        tx_ack = 1'b1;
      end else if (tx_ack && !data_valid && $urandom_range(0, 1) == 0) begin
        tx_ack = 1'b0;
      end
      wr_en = 1'b0;
      if (sent < 40 && !full && $urandom_range(0, 2) == 0) begin
        wr_en = 1'b1;
        wr_data = 8'(sent * 7 + 3);
        q.push_back(wr_data);
        sent++;
      end
    end
    wr_en = 1'b0;
    tx_ack = 1'b0;
    chk("wrap_count", 32'(got), 32'd40);

    // Stale ack held through reset blocks the request.
    tx_ack = 1'b1;
    do_reset(1'b0);
    wr_en = 1'b1;
    wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stale_%0d", i), 32'(data_valid), 32'd0);
    end
    tx_ack = 1'b0;
    step();
    chk("stale_rise", 32'(data_valid), 32'd1);
    chk("stale_data", 32'(data), 32'h5A);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    step();

    // Asynchronous reset while PRESENT with five bytes queued.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'hC0 + i);
      step();
    end
    wr_en = 1'b0;
    chk("ar_level", 32'(level), 32'd5);
    chk("ar_present", 32'(data_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(data_valid), 32'd0);
    chk("ar_level0", 32'(level), 32'd0);
    chk("ar_empty", 32'(empty), 32'd1);
    #2;
    rst_n = 1'b1;
    repeat (3) step();
    chk("ar_after", 32'(data_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
